multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Multi-cycle control FSM for the RV32I datapath subset: R, I (addi), load, store, branch, jal, jalr.
- Sequences each instruction through FETCH, DECODE, EXEC, MEM and WB, and drives datapath enables and mux selects.
- Handshakes with instruction and data memories, detects illegal opcodes and memory timeouts, and counts retired instructions.
- Sits between the instruction register and the shared ALU/regfile/PC datapath.

Parameters:
MEM_TIMEOUT, 16, max wait cycles for imem_ready/dmem_ready before bus error (must be ≥1)
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
opcode  in  7  instr[6:0] from instruction register
branch_taken  in  1  branch comparator result, valid in EXEC
imem_ready  in  1  instruction memory data valid
dmem_ready  in  1  data memory access complete
imem_req  out  1  instruction fetch request
ir_write  out  1  load instruction register
dmem_read  out  1  data memory read request
dmem_write  out  1  data memory write request
alu_src  out  1  0=rs2, 1=immediate
reg_write  out  1  register file write enable
mem_to_reg  out  2  00 ALU, 01 mem, 10 PC+4 (jal), 11 PC+4 (jalr)
pc_write  out  1  PC update enable
pc_sel  out  2  00 PC+4, 01 PC+imm (branch/jal), 10 rs1+imm (jalr)
illegal  out  1  sticky illegal-opcode flag
bus_err  out  1  sticky memory-timeout flag
state  out  3  current state, for debug
instret  out  CNT_W  retired instruction count

Behaviour:
- Encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.
- All state, op_q, wait counter, flags and instret are registered; they update only on posedge clk.
- All other outputs are combinational from state, op_q and the ready/branch_taken inputs.
- Reset (rst=1 at posedge, any state, including mid-MEM):
  - state=FETCH, op_q=0, wait counter=0, illegal=0, bus_err=0, instret=0.
  - While rst is high, every other output is forced to 0.
  - Outstanding memory requests are dropped, with no handshake completion.
- FETCH:
  - imem_req=1.
  - When imem_ready=1: ir_write=1 in that cycle, then go to DECODE.
  - Otherwise stay in FETCH and increment the wait counter.
- DECODE:
  - op_q <= opcode.
  - Opcode in the supported set (0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111) -> EXEC.
  - Any other opcode -> TRAP and set illegal.
- EXEC:
  - alu_src=1 for I, load, store, jalr; 0 otherwise.
  - R/I/jal/jalr -> WB. Load/store -> MEM.
  - Branch: pc_write=1; pc_sel=01 if branch_taken else 00; increment instret; go to FETCH.
- MEM:
  - Load: dmem_read=1. Store: dmem_write=1. The request is held until dmem_ready=1.
  - On dmem_ready, a load goes to WB.
  - On dmem_ready, a store asserts pc_write=1 with pc_sel=00, increments instret and goes to FETCH.
- WB:
  - reg_write=1, pc_write=1, increment instret, then go to FETCH.
  - mem_to_reg: 00 for R/I, 01 for load, 10 for jal, 11 for jalr.
  - pc_sel: 00 for R/I/load, 01 for jal, 10 for jalr.
- Wait counter:
  - Cleared on entry to FETCH or MEM and whenever the corresponding ready is seen.
  - If it reaches MEM_TIMEOUT with ready still low: set bus_err, go to TRAP, and deassert the request next cycle.
- TRAP:
  - All enables and requests are 0. pc_sel=00, mem_to_reg=00.
  - Remains in TRAP until rst; the illegal and bus_err flags hold.
- Cycle counts with zero wait states (ready high on the first request cycle):
  - Branch: 3 cycles.
  - R, I, jal, jalr and store: 4 cycles each.
  - Load: 5 cycles.
  - Each wait cycle adds 1.
- instret wraps modulo 2^CNT_W; exactly one increment per retired instruction.
- pc_write is 0 in FETCH and DECODE.
- reg_write is asserted only in WB.
- Outputs marked don't-care in a state must still be driven to 0; no X on any output.

Test Plan:
- Reset, then R-type (0110011) with imem_ready=1 -> states 0,1,2,4,0. reg_write=1 and pc_write=1 with pc_sel=00 only in WB. instret=1 after 4 cycles.
- Load (0000011) with dmem_ready low for 2 MEM cycles -> dmem_read held 3 cycles, mem_to_reg=01 in WB, 7 cycles total, instret+1.
- Branch (1100011) with branch_taken=1, then branch_taken=0 -> EXEC gives pc_sel=01, then 00. Each branch takes 3 cycles, never asserts reg_write, and increments instret.
- jalr (1100111) -> alu_src=1 in EXEC; WB has mem_to_reg=11 and pc_sel=10.
- Opcode 7'b1111111 -> TRAP after DECODE, illegal=1, all enables 0 for 20 cycles. rst=1 -> state=0, illegal=0.
- Store with dmem_ready held low and MEM_TIMEOUT=16 -> bus_err=1 and TRAP after 16 wait cycles. Separately, assert rst mid-MEM -> FETCH next cycle, dmem_write=0, instret=0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for an RV32I subset: sequences FETCH/DECODE/EXEC/MEM/WB,
// drives datapath enables, flags illegal opcodes and memory timeouts, counts retirements.
//
// state  | meaning
// FETCH  | request instruction, wait for imem_ready
// DECODE | latch opcode, check it is supported
// EXEC   | ALU operation; branches resolve and retire here
// MEM    | data memory access; stores retire here
// WB     | register write-back and PC update
// TRAP   | illegal opcode or bus timeout, held until reset
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic             branch_taken,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             ir_write,
    output logic             dmem_read,
    output logic             dmem_write,
    output logic             alu_src,
    output logic             reg_write,
    output logic [1:0]       mem_to_reg,
    output logic             pc_write,
    output logic [1:0]       pc_sel,
    output logic             illegal,
    output logic             bus_err,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instret
);
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic [6:0]        op_q, op_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              illegal_q, illegal_d;
    logic              bus_err_q, bus_err_d;
    logic [CNT_W-1:0]  instret_q;
    logic              retire;
    logic              timeout;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            op_q      <= 7'd0;
            wait_q    <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            wait_q    <= wait_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
            if (retire) instret_q <= instret_q + CNT_ONE;
        end
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        wait_d     = wait_q;
        illegal_d  = illegal_q;
        bus_err_d  = bus_err_q;
        retire     = 1'b0;
        imem_req   = 1'b0;
        ir_write   = 1'b0;
        dmem_read  = 1'b0;
        dmem_write = 1'b0;
        alu_src    = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 2'b00;
        pc_write   = 1'b0;
        pc_sel     = 2'b00;
        timeout    = (wait_q == WAIT_LAST);

        case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_write = 1'b1;
                    wait_d   = '0;
                    state_d  = S_DECODE;
                end else if (timeout) begin
                    bus_err_d = 1'b1;
                    state_d   = S_TRAP;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_DECODE: begin
                op_d = opcode;
                case (opcode)
                    OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR:
                        state_d = S_EXEC;
                    default: begin
                        illegal_d = 1'b1;
                        state_d   = S_TRAP;
                    end
                endcase
            end
            S_EXEC: begin
                alu_src = (op_q == OP_I) || (op_q == OP_LOAD) ||
                          (op_q == OP_STORE) || (op_q == OP_JALR);
                case (op_q)
                    OP_R, OP_I, OP_JAL, OP_JALR: state_d = S_WB;
                    OP_LOAD, OP_STORE: begin
                        wait_d  = '0;
                        state_d = S_MEM;
                    end
                    OP_BRANCH: begin
                        pc_write = 1'b1;
                        pc_sel   = branch_taken ? 2'b01 : 2'b00;
                        retire   = 1'b1;
                        wait_d   = '0;
                        state_d  = S_FETCH;
                    end
                    default: state_d = S_TRAP;
                endcase
            end
            S_MEM: begin
                dmem_read  = (op_q == OP_LOAD);
                dmem_write = (op_q == OP_STORE);
                if (dmem_ready) begin
                    wait_d = '0;
                    if (op_q == OP_STORE) begin
                        pc_write = 1'b1;
                        retire   = 1'b1;
                        state_d  = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (timeout) begin
                    bus_err_d = 1'b1;
                    state_d   = S_TRAP;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_WB: begin
                reg_write = 1'b1;
                pc_write  = 1'b1;
                retire    = 1'b1;
                wait_d    = '0;
                state_d   = S_FETCH;
                case (op_q)
                    OP_LOAD: mem_to_reg = 2'b01;
                    OP_JAL: begin
                        mem_to_reg = 2'b10;
                        pc_sel     = 2'b01;
                    end
                    OP_JALR: begin
                        mem_to_reg = 2'b11;
                        pc_sel     = 2'b10;
                    end
                    default: mem_to_reg = 2'b00;
                endcase
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_TRAP;
        endcase

        // Reset wins over everything visible on the datapath side.
        if (rst) begin
            imem_req   = 1'b0;
            ir_write   = 1'b0;
            dmem_read  = 1'b0;
            dmem_write = 1'b0;
            alu_src    = 1'b0;
            reg_write  = 1'b0;
            mem_to_reg = 2'b00;
            pc_write   = 1'b0;
            pc_sel     = 2'b00;
        end
    end

    assign illegal = illegal_q;
    assign bus_err = bus_err_q;
    assign state   = state_q;
    assign instret = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Trace-based bench: each instruction is expanded into an expected per-cycle
// output trace from its class and wait-state counts, then played against the DUT.
module tb_multicycle_ctrl;
    localparam int TO = 16;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  opcode;
    logic        branch_taken, imem_ready, dmem_ready;
    logic        imem_req, ir_write, dmem_read, dmem_write, alu_src, reg_write;
    logic [1:0]  mem_to_reg, pc_sel;
    logic        pc_write, illegal, bus_err;
    logic [2:0]  state;
    logic [31:0] instret;

    multicycle_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .branch_taken(branch_taken),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready), .imem_req(imem_req),
        .ir_write(ir_write), .dmem_read(dmem_read), .dmem_write(dmem_write),
        .alu_src(alu_src), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
        .pc_write(pc_write), .pc_sel(pc_sel), .illegal(illegal), .bus_err(bus_err),
        .state(state), .instret(instret)
    );

    always #5 clk = ~clk;

    // {state, imem_req, ir_write, dmem_read, dmem_write, alu_src, reg_write,
    //  mem_to_reg, pc_write, pc_sel, illegal, bus_err}
    logic [15:0] ov_act;
    assign ov_act = {state, imem_req, ir_write, dmem_read, dmem_write, alu_src,
                     reg_write, mem_to_reg, pc_write, pc_sel, illegal, bus_err};

    typedef struct {
        logic        rst;
        logic [6:0]  op;
        logic        ir, dr, bt;
        logic [15:0] ov;
        logic [31:0] cnt;
        bit          regs;
    } cyc_t;

    cyc_t        q[$];
    int          total = 0;
    int          bad = 0;
    int          idx = 0;
    bit          ill_m, be_m;
    logic [31:0] cnt_m;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [2:0] st, input logic [6:0] op, input bit ir,
                        input bit dr, input bit bt, input logic [5:0] en,
                        input logic [1:0] m2r, input bit pw, input logic [1:0] psel);
        cyc_t c;
        c.rst = 1'b0; c.op = op; c.ir = ir; c.dr = dr; c.bt = bt;
        c.ov = {st, en, m2r, pw, psel, ill_m, be_m};
        c.cnt = cnt_m; c.regs = 1'b1;
        q.push_back(c);
    endtask

    task automatic add_trap(input int n, input logic [6:0] op);
        repeat (n) push(3'd5, op, 0, 0, 0, 6'b0, 2'b00, 0, 2'b00);
    endtask

    // Registered outputs are unknown on reset cycles (they still show the old state).
    task automatic add_reset(input int n);
        cyc_t c;
        c.rst = 1'b1; c.op = 7'd0; c.ir = 1'b0; c.dr = 1'b0; c.bt = 1'b0;
        c.ov = 16'h0; c.cnt = 32'd0; c.regs = 1'b0;
        repeat (n) q.push_back(c);
        ill_m = 1'b0; be_m = 1'b0; cnt_m = 32'd0;
    endtask

    // wi/wd: low-ready cycles before imem/dmem respond; abort: stop after that many MEM cycles
    task automatic add_instr(input logic [6:0] op, input int wi, input int wd,
                             input bit bt, input int abort);
        bit          legal, asrc, is_ld, is_st;
        logic [5:0]  men;
        logic [1:0]  m2r, psel;
        legal = op inside {OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR};
        asrc  = op inside {OP_I, OP_LOAD, OP_STORE, OP_JALR};
        is_ld = (op == OP_LOAD);
        is_st = (op == OP_STORE);
        for (int i = 0; i < wi; i++) begin
            push(3'd0, op, 0, 0, 0, 6'b100000, 2'b00, 0, 2'b00);
            if (i + 1 == TO) begin
                be_m = 1'b1;
                add_trap(8, op);
                return;
            end
        end
        push(3'd0, op, 1, 0, 0, 6'b110000, 2'b00, 0, 2'b00);
        push(3'd1, op, 0, 0, 0, 6'b000000, 2'b00, 0, 2'b00);
        if (!legal) begin
            ill_m = 1'b1;
            add_trap(20, op);
            return;
        end
        if (op == OP_BRANCH) begin
            push(3'd2, op, 0, 0, bt, 6'b000000, 2'b00, 1, bt ? 2'b01 : 2'b00);
            cnt_m++;
            return;
        end
        push(3'd2, op, 0, 0, 0, {4'b0000, asrc, 1'b0}, 2'b00, 0, 2'b00);
        if (is_ld || is_st) begin
            men = is_ld ? 6'b001000 : 6'b000100;
            for (int i = 0; i < wd; i++) begin
                push(3'd3, op, 0, 0, 0, men, 2'b00, 0, 2'b00);
                if (abort > 0 && i + 1 == abort) return;
                if (i + 1 == TO) begin
                    be_m = 1'b1;
                    add_trap(8, op);
                    return;
                end
            end
            if (is_st) begin
                push(3'd3, op, 0, 1, 0, men, 2'b00, 1, 2'b00);
                cnt_m++;
                return;
            end
            push(3'd3, op, 0, 1, 0, men, 2'b00, 0, 2'b00);
        end
        m2r  = is_ld ? 2'b01 : (op == OP_JAL) ? 2'b10 : (op == OP_JALR) ? 2'b11 : 2'b00;
        psel = (op == OP_JAL) ? 2'b01 : (op == OP_JALR) ? 2'b10 : 2'b00;
        push(3'd4, op, 0, 0, 0, 6'b000001, m2r, 1, psel);
        cnt_m++;
    endtask

    task automatic run_queue();
        logic [15:0] mask;
        while (q.size() > 0) begin
            cyc_t c;
            c = q.pop_front();
            @(posedge clk);
            #1;
            rst = c.rst; opcode = c.op; imem_ready = c.ir;
            dmem_ready = c.dr; branch_taken = c.bt;
            @(negedge clk);
            mask = c.regs ? 16'hFFFF : 16'h1FFC;
            chk($sformatf("cyc%0d outs", idx), ov_act & mask, c.ov & mask);
            if (c.regs) chk($sformatf("cyc%0d instret", idx), instret, c.cnt);
            idx++;
        end
    endtask

    int n;

    initial begin
        rst = 1'b1; opcode = 7'd0; branch_taken = 1'b0;
        imem_ready = 1'b0; dmem_ready = 1'b0;
        ill_m = 1'b0; be_m = 1'b0; cnt_m = 32'd0;

        add_reset(2);
        run_queue();

        n = q.size(); add_instr(OP_R, 0, 0, 0, 0);
        chk("len r-type", q.size() - n, 4);
        run_queue();
        chk("r-type wb", {reg_write, pc_write, pc_sel}, 4'b1100);

        n = q.size(); add_instr(OP_LOAD, 0, 2, 0, 0);
        chk("len load 2 waits", q.size() - n, 7);
        run_queue();
        chk("load wb mem_to_reg", mem_to_reg, 2'b01);

        n = q.size(); add_instr(OP_BRANCH, 0, 0, 1, 0);
        chk("len branch", q.size() - n, 3);
        run_queue();
        chk("branch taken exec", {pc_write, pc_sel}, 3'b101);
        add_instr(OP_BRANCH, 0, 0, 0, 0);
        run_queue();
        chk("branch not taken exec", {pc_write, pc_sel, reg_write}, 4'b1000);

        add_instr(OP_JALR, 0, 0, 0, 0);
        run_queue();
        chk("jalr wb", {mem_to_reg, pc_sel}, 4'b1110);

        add_instr(OP_JAL, 1, 0, 0, 0);
        add_instr(OP_I, 0, 0, 0, 0);
        n = q.size(); add_instr(OP_STORE, 0, 1, 0, 0);
        chk("len store 1 wait", q.size() - n, 5);
        run_queue();
        chk("instret model after 8", cnt_m, 32'd8);

        add_instr(7'b1111111, 0, 0, 0, 0);
        run_queue();
        chk("illegal trap", {state, illegal}, 4'b1011);

        add_reset(1);
        add_instr(OP_STORE, 0, 20, 0, 0);
        run_queue();
        chk("store timeout", {state, bus_err, dmem_write}, 5'b10110);

        add_reset(1);
        add_instr(OP_STORE, 0, 5, 0, 2);
        add_reset(1);
        add_instr(OP_R, 0, 0, 0, 0);
        run_queue();
        @(posedge clk);
        #1;
        imem_ready = 1'b0;
        @(negedge clk);
        chk("instret after mid-mem reset", instret, 32'd1);

        add_reset(1);
        add_instr(OP_R, 20, 0, 0, 0);
        run_queue();
        chk("fetch timeout", {state, bus_err, imem_req}, 5'b10110);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
